// File: rtl/fifo_v4_pkg.sv
// Shared helpers and types for the fifo_v4 decoupling queue.
package fifo_v4_pkg;

  // Widest supported DEPTH is 2**16, so a 17-bit count covers every build.
  localparam int unsigned FIFO_MAX_ADDR_W   = 16;
  localparam int unsigned FIFO_AE_TH_DEFAULT = 1;
  localparam int unsigned FIFO_AF_TH_MARGIN  = 1;

  typedef logic [FIFO_MAX_ADDR_W:0] fifo_cnt_t;

  // Pointer width for a given depth; at least one bit.
  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_v4_ptr.sv
// Wrapping pointer for fifo_v4: counts 0..DEPTH-1 and wraps, any DEPTH.
module fifo_v4_ptr
  import fifo_v4_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = fifo_addr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_v4.sv
// Synchronous valid/ready FIFO with occupancy flags and optional fall-through.
// Macro FIFO_V4_PEAK_STATS_EN enables the peak_usage_o high-water register.
module fifo_v4
  import fifo_v4_pkg::*;
#(
  parameter bit          FALL_THROUGH    = 1'b0,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - FIFO_AF_TH_MARGIN,
  parameter int unsigned ALMOST_EMPTY_TH = FIFO_AE_TH_DEFAULT,
  localparam int unsigned ADDR_DEPTH     = fifo_addr_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_DEPTH:0]   usage_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_DEPTH:0]   peak_usage_o
);

  localparam int unsigned CNT_W = ADDR_DEPTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rptr, wptr;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop, bypass, wr_en, rd_en;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  // Flags come only from the registered count, keeping ready paths short.
  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = fifo_cnt_t'(count_q) >= fifo_cnt_t'(ALMOST_FULL_TH);
  assign almost_empty_o = fifo_cnt_t'(count_q) <= fifo_cnt_t'(ALMOST_EMPTY_TH);
  assign usage_o        = count_q;

  assign in_ready_o  = ~full_o;
  assign bypass      = FALL_THROUGH && empty_o;
  assign out_valid_o = bypass ? in_valid_i : ~empty_o;
  assign out_data_o  = bypass ? in_data_i : mem_q[rptr];

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // A bypassed beat that is consumed immediately never touches storage.
  assign wr_en = push & ~flush_i & ~(bypass & pop);
  assign rd_en = pop & ~flush_i & ~bypass;

  fifo_v4_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (wr_en),
    .ptr_o  (wptr)
  );

  fifo_v4_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (rd_en),
    .ptr_o  (rptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wptr] <= in_data_i;
    end
  end

`ifdef FIFO_V4_PEAK_STATS_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (flush_i) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) peak_q <= '0;
    else         peak_q <= peak_d;
  end

  assign peak_usage_o = peak_q;
`else
  assign peak_usage_o = '0;
`endif

`ifndef SYNTHESIS
  if (DEPTH < 2 || DEPTH > 65536) begin : g_bad_depth
    $error("fifo_v4: DEPTH out of range 2..65536");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("fifo_v4: ALMOST_FULL_TH out of range 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_v4: ALMOST_EMPTY_TH out of range 0..DEPTH-1");
  end

  a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (in_valid_i && !in_ready_o && !flush_i) |=> in_valid_i)
    else $error("fifo_v4: in_valid_i dropped while in_ready_o low");
`endif

endmodule

// File: tb/tb_fifo_v4.sv
// Directed self-checking bench for fifo_v4 (DEPTH=4, 8-bit, FT=0 and FT=1).
module tb_fifo_v4;

`ifdef FIFO_V4_PEAK_STATS_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       flush, flush2, tmode;
  logic       iv, ordy, iv2, ordy2;
  logic [7:0] id, id2;
  logic       ir, ov, full, empty, af, ae;
  logic       ir2, ov2, full2, empty2, af2, ae2;
  logic [7:0] od, od2;
  logic [2:0] usage, peak, usage2, peak2;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4),
            .ALMOST_FULL_TH(3), .ALMOST_EMPTY_TH(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(tmode),
    .in_valid_i(iv), .in_ready_o(ir), .in_data_i(id),
    .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od),
    .usage_o(usage), .full_o(full), .empty_o(empty),
    .almost_full_o(af), .almost_empty_o(ae), .peak_usage_o(peak)
  );

  fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4),
            .ALMOST_FULL_TH(3), .ALMOST_EMPTY_TH(1)) u_dut_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2), .testmode_i(tmode),
    .in_valid_i(iv2), .in_ready_o(ir2), .in_data_i(id2),
    .out_valid_o(ov2), .out_ready_i(ordy2), .out_data_o(od2),
    .usage_o(usage2), .full_o(full2), .empty_o(empty2),
    .almost_full_o(af2), .almost_empty_o(ae2), .peak_usage_o(peak2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_peak(input int v);
    return PEAK_ON ? 3'(v) : 3'd0;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush2 = 1'b0; tmode = 1'b0;
    iv = 1'b0; ordy = 1'b0; id = 8'h00;
    iv2 = 1'b0; ordy2 = 1'b0; id2 = 8'h00;
    #12;
    chk("rst_in_ready",  32'(ir),    1);
    chk("rst_out_valid", 32'(ov),    0);
    chk("rst_usage",     32'(usage), 0);
    chk("rst_full",      32'(full),  0);
    chk("rst_empty",     32'(empty), 1);
    chk("rst_ae",        32'(ae),    1);
    chk("rst_af",        32'(af),    0);
    chk("rst_peak",      32'(peak),  0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Fill with out_ready low; check usage and both thresholds on the way up.
    for (int i = 0; i < 4; i++) begin
      iv = 1'b1; id = 8'hA1 + 8'(i);
      step();
      chk($sformatf("fill_usage_%0d", i + 1), 32'(usage), 32'(i + 1));
      chk($sformatf("fill_ae_%0d", i + 1),    32'(ae),    32'((i + 1) <= 1));
      chk($sformatf("fill_af_%0d", i + 1),    32'(af),    32'((i + 1) >= 3));
    end
    chk("full_flag",     32'(full), 1);
    chk("full_in_ready", 32'(ir),   0);
    chk("full_head",     32'(od),   32'hA1);
    chk("full_peak",     32'(peak), 32'(exp_peak(4)));

    // A5 held pending while full.
    id = 8'hA5;
    step();
    chk("pending_usage", 32'(usage), 4);

    // Full with in_valid and out_ready together: pop only.
    ordy = 1'b1;
    #1;
    chk("full_ready_indep", 32'(ir), 0);
    step();
    chk("pop1_usage", 32'(usage), 3);
    chk("pop1_head",  32'(od),    32'hA2);
    step();
    iv = 1'b0;
    chk("pop2_usage", 32'(usage), 3);
    chk("pop2_head",  32'(od),    32'hA3);
    step();
    chk("pop3_head",  32'(od),    32'hA4);
    step();
    chk("pop4_head",  32'(od),    32'hA5);
    chk("pop4_usage", 32'(usage), 1);
    step();
    chk("drain_empty", 32'(empty), 1);
    chk("drain_valid", 32'(ov),    0);

    // Streaming at usage 2: pointers wrap repeatedly, order preserved.
    ordy = 1'b0; iv = 1'b1;
    id = 8'hB0; step();
    id = 8'hB1; step();
    ordy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      id = 8'hB2 + 8'(k);
      #1;
      chk($sformatf("stream_data_%0d", k), 32'(od), 32'(8'hB0 + 8'(k)));
      step();
      chk($sformatf("stream_usage_%0d", k), 32'(usage), 2);
    end
    iv = 1'b0;
    chk("stream_tail0", 32'(od), 32'hC4);
    step();
    chk("stream_tail1", 32'(od), 32'hC5);
    step();
    chk("stream_empty", 32'(empty), 1);

    // Fall-through instance.
    iv2 = 1'b1; id2 = 8'h5C; ordy2 = 1'b1;
    #1;
    chk("ft_valid_same", 32'(ov2), 1);
    chk("ft_data_same",  32'(od2), 32'h5C);
    step();
    chk("ft_bypass_usage", 32'(usage2), 0);
    ordy2 = 1'b0;
    step();
    iv2 = 1'b0;
    #1;
    chk("ft_store_usage", 32'(usage2), 1);
    chk("ft_store_data",  32'(od2),    32'h5C);
    chk("ft_store_valid", 32'(ov2),    1);

    // Fill to 3, then flush with a concurrent push.
    ordy = 1'b0; iv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = 8'hC1 + 8'(i);
      step();
    end
    chk("pre_flush_usage", 32'(usage), 3);
    chk("pre_flush_peak",  32'(peak),  32'(exp_peak(4)));
    flush = 1'b1; id = 8'hCC;
    step();
    flush = 1'b0; iv = 1'b0;
    chk("flush_usage", 32'(usage), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_valid", 32'(ov),    0);
    chk("flush_peak",  32'(peak),  0);

    // Reset mid-burst: outputs return to reset values at once.
    iv = 1'b1;
    id = 8'hD1; step();
    id = 8'hD2; step();
    chk("burst_usage", 32'(usage), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_usage", 32'(usage), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_valid", 32'(ov),    0);
    chk("mid_rst_ready", 32'(ir),    1);
    chk("mid_rst_data",  32'(od),    0);
    chk("mid_rst_peak",  32'(peak),  0);
    chk("mid_rst_ft_usage", 32'(usage2), 0);
    iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
